btb_update_queue: RTL and testbench

- Producer side of the branch target buffer's update and invalidation interface.
- Takes resolved-branch reports from the execute/commit stage and decides whether each one needs a target write, an entry invalidation, or nothing.
- Buffers the required actions in a FIFO and drives the buffer's Wr_En/Orig_PC/Target_PC and invalidate/pc_invalid ports.
- Issues up to two actions per cycle: one write plus one invalidation, provided they target different lines.

---
 rtl/btb_update_queue.sv | 165 ++++++++++++++++
 tb/tb_btb_update_queue.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/btb_update_queue.sv
// btb_update_queue: classifies resolved-branch reports into target writes or
// entry invalidations, queues them, and issues up to one write plus one
// invalidation per cycle to the branch target buffer.
module btb_update_queue #(
  parameter int PC_BITS = 32,
  parameter int SIZE    = 1024,
  parameter int DEPTH   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     res_valid,
  output logic                     res_ready,
  input  logic [PC_BITS-1:0]       res_pc,
  input  logic [PC_BITS-1:0]       res_target,
  input  logic                     res_taken,
  input  logic                     res_btb_hit,
  input  logic [PC_BITS-1:0]       res_pred_target,
  input  logic                     hold,
  output logic                     Wr_En,
  output logic [PC_BITS-1:0]       Orig_PC,
  output logic [PC_BITS-1:0]       Target_PC,
  output logic                     invalidate,
  output logic [PC_BITS-1:0]       pc_invalid,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int SEL_BITS = $clog2(SIZE);
  localparam int PTR_W    = $clog2(DEPTH);
  localparam int OCC_W    = PTR_W + 1;

  // Entry type encoding: a set bit means target write, clear means invalidate.
  localparam logic T_WR  = 1'b1;
  localparam logic T_INV = 1'b0;

  // Queue storage and bookkeeping
  logic               r_type [DEPTH];
  logic [PC_BITS-1:0] r_pc   [DEPTH];
  logic [PC_BITS-1:0] r_tgt  [DEPTH];
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [OCC_W-1:0]   r_occ;

  // Combinational decode
  logic               w_is_wr;
  logic               w_is_inv;
  logic               w_push;
  logic               w_full;
  logic               w_issue_en;
  logic               w_pair;
  logic [1:0]         w_issue_cnt;
  logic [PTR_W-1:0]   w_next_ptr;
  logic               w_head_type;
  logic               w_next_type;
  logic [PC_BITS-1:0] w_head_pc;
  logic [PC_BITS-1:0] w_next_pc;
  logic [PC_BITS-1:0] w_head_tgt;
  logic [PC_BITS-1:0] w_next_tgt;

  // Classify the incoming report; anything that is neither is a no-op.
  always_comb begin
    w_is_wr  = res_taken & (~res_btb_hit | (res_pred_target != res_target));
    w_is_inv = ~res_taken & res_btb_hit;
  end

  // Decide how many head entries issue this cycle, pairing opposite types on distinct lines.
  always_comb begin
    w_next_ptr  = r_rd_ptr + PTR_W'(1);
    w_head_type = r_type[r_rd_ptr];
    w_next_type = r_type[w_next_ptr];
    w_head_pc   = r_pc[r_rd_ptr];
    w_next_pc   = r_pc[w_next_ptr];
    w_head_tgt  = r_tgt[r_rd_ptr];
    w_next_tgt  = r_tgt[w_next_ptr];
    w_issue_en  = ~hold & ~flush & (r_occ != {OCC_W{1'b0}});
    w_pair      = w_issue_en
                & (r_occ >= OCC_W'(2))
                & (w_head_type != w_next_type)
                & (w_head_pc[SEL_BITS:1] != w_next_pc[SEL_BITS:1]);
    if (w_pair) begin
      w_issue_cnt = 2'd2;
    end else if (w_issue_en) begin
      w_issue_cnt = 2'd1;
    end else begin
      w_issue_cnt = 2'd0;
    end
  end

  // Backpressure: a same-cycle pop frees a slot; flush always reports ready.
  always_comb begin
    w_full    = (r_occ == OCC_W'(DEPTH));
    res_ready = ~w_full | (w_issue_cnt != 2'd0) | flush;
    w_push    = res_valid & res_ready & ~flush & (w_is_wr | w_is_inv);
  end

  // Drive buffer ports from the head (and paired head+1); idle buses stay 0.
  always_comb begin
    Wr_En      = 1'b0;
    Orig_PC    = {PC_BITS{1'b0}};
    Target_PC  = {PC_BITS{1'b0}};
    invalidate = 1'b0;
    pc_invalid = {PC_BITS{1'b0}};
    if (w_issue_en) begin
      if (w_head_type == T_WR) begin
        Wr_En     = 1'b1;
        Orig_PC   = w_head_pc;
        Target_PC = w_head_tgt;
        if (w_pair) begin
          invalidate = 1'b1;
          pc_invalid = w_next_pc;
        end else begin
          invalidate = 1'b0;
        end
      end else begin
        invalidate = 1'b1;
        pc_invalid = w_head_pc;
        if (w_pair) begin
          Wr_En     = 1'b1;
          Orig_PC   = w_next_pc;
          Target_PC = w_next_tgt;
        end else begin
          Wr_En = 1'b0;
        end
      end
    end else begin
      Wr_En = 1'b0;
    end
  end

  assign occupancy = r_occ;

  // Queue storage: write the accepted action at the tail. When full with a pop,
  // the tail equals the head being retired, so the slot is free at this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_type[i] <= T_INV;
        r_pc[i]   <= {PC_BITS{1'b0}};
        r_tgt[i]  <= {PC_BITS{1'b0}};
      end
    end else if (w_push) begin
      r_type[r_wr_ptr] <= w_is_wr ? T_WR : T_INV;
      r_pc[r_wr_ptr]   <= res_pc;
      r_tgt[r_wr_ptr]  <= w_is_wr ? res_target : {PC_BITS{1'b0}};
    end
  end

  // Pointer and occupancy update; flush empties the queue at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= {PTR_W{1'b0}};
      r_wr_ptr <= {PTR_W{1'b0}};
      r_occ    <= {OCC_W{1'b0}};
    end else if (flush) begin
      r_rd_ptr <= {PTR_W{1'b0}};
      r_wr_ptr <= {PTR_W{1'b0}};
      r_occ    <= {OCC_W{1'b0}};
    end else begin
      r_rd_ptr <= r_rd_ptr + PTR_W'(w_issue_cnt);
      r_wr_ptr <= r_wr_ptr + PTR_W'(w_push);
      r_occ    <= r_occ + OCC_W'(w_push) - OCC_W'(w_issue_cnt);
    end
  end

endmodule

// File: tb/tb_btb_update_queue.sv
// Directed self-checking bench for btb_update_queue.
module tb_btb_update_queue;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_pc;
  logic [31:0] res_target;
  logic        res_taken;
  logic        res_btb_hit;
  logic [31:0] res_pred_target;
  logic        hold;
  logic        Wr_En;
  logic [31:0] Orig_PC;
  logic [31:0] Target_PC;
  logic        invalidate;
  logic [31:0] pc_invalid;
  logic [3:0]  occupancy;

  int n_chk;
  int n_fail;

  btb_update_queue #(.PC_BITS(32), .SIZE(1024), .DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_pc(res_pc), .res_target(res_target), .res_taken(res_taken),
    .res_btb_hit(res_btb_hit), .res_pred_target(res_pred_target),
    .hold(hold), .Wr_En(Wr_En), .Orig_PC(Orig_PC), .Target_PC(Target_PC),
    .invalidate(invalidate), .pc_invalid(pc_invalid), .occupancy(occupancy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one report across a clock edge; returns at posedge+1 with valid dropped.
  task automatic send(input logic [31:0] pc, input logic [31:0] tgt,
                      input logic taken, input logic hit, input logic [31:0] pred);
    res_valid       = 1'b1;
    res_pc          = pc;
    res_target      = tgt;
    res_taken       = taken;
    res_btb_hit     = hit;
    res_pred_target = pred;
    @(posedge clk);
    #1;
    res_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0; flush = 1'b0; hold = 1'b0; res_valid = 1'b0;
    res_pc = 32'h0; res_target = 32'h0; res_taken = 1'b0;
    res_btb_hit = 1'b0; res_pred_target = 32'h0;
    #2;
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_ready", 32'(res_ready), 32'd1);
    chk("rst_wr", 32'(Wr_En), 32'd0);
    chk("rst_inv", 32'(invalidate), 32'd0);
    #10 rst_n = 1'b1;
    step();

    // Single write
    send(32'h100, 32'h200, 1'b1, 1'b0, 32'h0);
    chk("wr_en", 32'(Wr_En), 32'd1);
    chk("wr_orig", Orig_PC, 32'h100);
    chk("wr_tgt", Target_PC, 32'h200);
    chk("wr_noinv", 32'(invalidate), 32'd0);
    step();
    chk("wr_occ0", 32'(occupancy), 32'd0);
    chk("wr_idle", 32'(Wr_En), 32'd0);

    // Single invalidate
    send(32'h104, 32'h0, 1'b0, 1'b1, 32'h0);
    chk("inv_en", 32'(invalidate), 32'd1);
    chk("inv_pc", pc_invalid, 32'h104);
    chk("inv_nowr", 32'(Wr_En), 32'd0);
    chk("inv_orig0", Orig_PC, 32'h0);
    step();

    // Correctly predicted taken branch: nothing to do
    send(32'h108, 32'h300, 1'b1, 1'b1, 32'h300);
    chk("nop_occ", 32'(occupancy), 32'd0);
    chk("nop_wr", 32'(Wr_En), 32'd0);
    chk("nop_inv", 32'(invalidate), 32'd0);

    // Pairing of INV + WR on different lines
    hold = 1'b1;
    send(32'h10, 32'h0, 1'b0, 1'b1, 32'h0);
    send(32'h20, 32'h80, 1'b1, 1'b0, 32'h0);
    send(32'h30, 32'h90, 1'b1, 1'b0, 32'h0);
    chk("pair_occ3", 32'(occupancy), 32'd3);
    chk("pair_hold_wr", 32'(Wr_En), 32'd0);
    hold = 1'b0;
    #1;
    chk("pair_inv", 32'(invalidate), 32'd1);
    chk("pair_invpc", pc_invalid, 32'h10);
    chk("pair_wr", 32'(Wr_En), 32'd1);
    chk("pair_orig", Orig_PC, 32'h20);
    chk("pair_tgt", Target_PC, 32'h80);
    step();
    chk("pair_occ1", 32'(occupancy), 32'd1);
    chk("pair2_wr", 32'(Wr_En), 32'd1);
    chk("pair2_orig", Orig_PC, 32'h30);
    chk("pair2_tgt", Target_PC, 32'h90);
    chk("pair2_noinv", 32'(invalidate), 32'd0);
    step();
    chk("pair_occ0", 32'(occupancy), 32'd0);

    // Same line index: no pairing
    hold = 1'b1;
    send(32'h0, 32'h0, 1'b0, 1'b1, 32'h0);
    send(32'h1000, 32'h2000, 1'b1, 1'b0, 32'h0);
    hold = 1'b0;
    #1;
    chk("same_inv", 32'(invalidate), 32'd1);
    chk("same_invpc", pc_invalid, 32'h0);
    chk("same_nowr", 32'(Wr_En), 32'd0);
    step();
    chk("same_occ1", 32'(occupancy), 32'd1);
    chk("same_wr", 32'(Wr_En), 32'd1);
    chk("same_orig", Orig_PC, 32'h1000);
    chk("same_noinv", 32'(invalidate), 32'd0);
    step();
    chk("same_occ0", 32'(occupancy), 32'd0);

    // Full queue and same-cycle push with pop
    hold = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(32'h4000 + 32'(i) * 32'h10, 32'h8000 + 32'(i), 1'b1, 1'b0, 32'h0);
    end
    chk("full_occ", 32'(occupancy), 32'd8);
    chk("full_ready", 32'(res_ready), 32'd0);
    hold = 1'b0;
    res_valid = 1'b1; res_pc = 32'h4080; res_target = 32'h8008;
    res_taken = 1'b1; res_btb_hit = 1'b0;
    #1;
    chk("full_ready_pop", 32'(res_ready), 32'd1);
    chk("full_head", Orig_PC, 32'h4000);
    step();
    res_valid = 1'b0;
    chk("full_occ_keep", 32'(occupancy), 32'd8);
    for (int i = 1; i < 9; i++) begin
      chk("drain_orig", Orig_PC, 32'h4000 + 32'(i) * 32'h10);
      chk("drain_tgt", Target_PC, 32'h8000 + 32'(i));
      step();
    end
    chk("drain_occ0", 32'(occupancy), 32'd0);

    // Flush with queued entries and a report in the flush cycle
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(32'h500 + 32'(i) * 32'h4, 32'h600, 1'b1, 1'b0, 32'h0);
    end
    chk("fl_occ5", 32'(occupancy), 32'd5);
    hold = 1'b0;
    flush = 1'b1;
    res_valid = 1'b1; res_pc = 32'h700; res_target = 32'h800;
    res_taken = 1'b1; res_btb_hit = 1'b0;
    #1;
    chk("fl_wr", 32'(Wr_En), 32'd0);
    chk("fl_inv", 32'(invalidate), 32'd0);
    chk("fl_ready", 32'(res_ready), 32'd1);
    step();
    flush = 1'b0;
    res_valid = 1'b0;
    #1;
    chk("fl_occ0", 32'(occupancy), 32'd0);
    chk("fl_after_wr", 32'(Wr_En), 32'd0);
    step();
    chk("fl_after2_wr", 32'(Wr_En), 32'd0);
    chk("fl_after2_occ", 32'(occupancy), 32'd0);

    // Reset mid-drain
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(32'h900 + 32'(i) * 32'h4, 32'hA00, 1'b1, 1'b0, 32'h0);
    end
    hold = 1'b0;
    #1;
    chk("rd_wr_before", 32'(Wr_En), 32'd1);
    step();
    rst_n = 1'b0;
    #1;
    chk("rd_wr", 32'(Wr_En), 32'd0);
    chk("rd_orig", Orig_PC, 32'h0);
    chk("rd_occ", 32'(occupancy), 32'd0);
    #2 rst_n = 1'b1;
    step();
    chk("rd_occ_after", 32'(occupancy), 32'd0);
    chk("rd_ready_after", 32'(res_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
